edge_gen: RTL
=============

// Module: edge_gen
// PURPOSE
//  Transmit-side counterpart to the rise/fall edge detector: turns single-cycle rise/fall
//  request strobes into a registered, glitch-free level output with minimum high/low times.
//  Drives slow control lines (enables, strobes, handshake wires) that a far-end detector samples.
//  Queues one pending request while a minimum-width hold is still running.
// PARAMETERS
//  MIN_HIGH  4   min cycles a_out stays 1 after a rising edge (>=1)
//  MIN_LOW   4   min cycles a_out stays 0 after a falling edge (>=1)
//  PULSE_LEN 8   auto-fall length in cycles, used only with EDGE_GEN_AUTOFALL_EN (>=MIN_HIGH)
//  CNT_W     8   hold counter width; must hold max(MIN_HIGH,MIN_LOW,PULSE_LEN)
// PORTS
//  clk       in   1  clock, all logic on posedge
//  rst_n     in   1  synchronous reset, active-low
//  rise_req  in   1  request a 0->1 edge (1-cycle strobe)
//  fall_req  in   1  request a 1->0 edge (1-cycle strobe)
//  a_out     out  1  generated level, registered
//  rise_done out  1  1-cycle pulse, same cycle a_out first reads 1
//  fall_done out  1  1-cycle pulse, same cycle a_out first reads 0
//  busy      out  1  1 while a min-width hold runs or a request is pending
//  err       out  1  1-cycle pulse: request dropped (see rules)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=LOW_IDLE, a_out=0, rise_done=0, fall_done=0, busy=0, err=0,
//   counter=0, pending cleared. Reset mid-hold aborts the hold and drops the pending request.
//  FSM: LOW_IDLE, HOLD_HIGH, HIGH_IDLE, HOLD_LOW.
//   LOW_IDLE  + rise_req at cycle N -> a_out=1, rise_done=1 at N+1; HOLD_HIGH, cnt=MIN_HIGH-1.
//   HOLD_HIGH: cnt decrements each cycle; at cnt==0 -> a pending fall fires (a_out=0 next cycle,
//    fall_done=1, HOLD_LOW, cnt=MIN_LOW-1), else -> HIGH_IDLE.
//   HIGH_IDLE + fall_req -> a_out=0, fall_done=1 next cycle; HOLD_LOW, cnt=MIN_LOW-1.
//   HOLD_LOW symmetric to HOLD_HIGH with a pending rise.
//  Net effect: a_out high for exactly max(MIN_HIGH, time to fall_req+1) cycles; same for low.
//  Pending: one-deep, opposite-polarity only. fall_req during HOLD_HIGH is pended; a second one
//   while pending is redundant and ignored (no err).
//  Same-polarity request (rise_req while a_out=1 or HOLD_HIGH; fall_req while low) -> ignored, err=1.
//  rise_req & fall_req in the same cycle -> both ignored, err=1, state unchanged.
//  Opposite request during hold while the pending opposite edge is already queued -> keep pending.
//  busy = (state==HOLD_HIGH || state==HOLD_LOW) || pending; registered.
//  Counter never wraps: loaded only on an edge, saturates at 0.
// CONFIGURATION
//  EDGE_GEN_AUTOFALL_EN defined: each rising edge also queues an automatic fall; a_out drops
//   exactly PULSE_LEN cycles after rising (cnt loaded PULSE_LEN-1) unless fall_req comes earlier
//   and MIN_HIGH has elapsed; fall_done pulses as normal. HIGH_IDLE is unreachable.
//  Not defined: no auto-fall; a_out stays high until fall_req. PULSE_LEN unused.
// STRUCTURE
//  edge_pkg: state typedef (LOW_IDLE, HOLD_HIGH, HIGH_IDLE, HOLD_LOW), localparam encodings,
//   shared with the edge detector bench.
//  One sub-module: edge_hold_cnt (load value, load strobe, decrement, zero flag, CNT_W wide).
//  FSM, pending flag and output registers stay in edge_gen.
// TESTING
//  1 Reset: hold rst_n=0 2 cycles with rise_req=1 -> a_out=0, busy=0, err=0, no done pulses.
//  2 MIN_HIGH=4: rise_req@0, fall_req@1 -> a_out=1 cycles 1-4, fall_done@5, a_out=0@5, busy 1-8.
//  3 HIGH_IDLE: rise_req@0, fall_req@10 -> fall_done@11; rise_req@12 pended, rise_done@15.
//  4 rise_req&fall_req@0 in LOW_IDLE -> err@1, a_out stays 0; fall_req while low -> err, no edge.
//  5 rst_n=0 during HOLD_HIGH with fall pended -> a_out=0 next cycle, no fall_done, pending lost.
//  6 EDGE_GEN_AUTOFALL_EN, PULSE_LEN=8: rise_req@0 only -> a_out=1 cycles 1-8, fall_done@9.
//  Bench also checks a_out against the edge detector: each rise_done/fall_done gives one detection.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared definitions for the edge generator and its matching edge-detector bench.
// State type and legacy-compatible state encodings.
package edge_pkg;

  typedef logic [1:0] state_t;

  localparam state_t LOW_IDLE  = 2'd0;
  localparam state_t HOLD_HIGH = 2'd1;
  localparam state_t HIGH_IDLE = 2'd2;
  localparam state_t HOLD_LOW  = 2'd3;

endpackage

// File: rtl/edge_gen_if.sv
// Request/status bundle between a requester (master) and the edge generator (slave).
interface edge_gen_if;

  logic rise_req;
  logic fall_req;
  logic a_out;
  logic rise_done;
  logic fall_done;
  logic busy;
  logic err;

  modport master (
    output rise_req, fall_req,
    input  a_out, rise_done, fall_done, busy, err
  );

  modport slave (
    input  rise_req, fall_req,
    output a_out, rise_done, fall_done, busy, err
  );

endinterface

// File: rtl/edge_hold_cnt.sv
// Minimum-width hold counter: loads on an edge, counts down, saturates at zero.
module edge_hold_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] thr,
  output logic             zero,
  output logic             le_thr
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero   = (cnt_q == '0);
  assign le_thr = (cnt_q <= thr);

endmodule

// File: rtl/edge_gen.sv
// Request-driven level generator with minimum high/low times and a one-deep pending edge.
// Optional EDGE_GEN_AUTOFALL_EN: every rise also queues a fall PULSE_LEN cycles later.
module edge_gen
  import edge_pkg::*;
#(
  parameter int unsigned MIN_HIGH  = 4,
  parameter int unsigned MIN_LOW   = 4,
  parameter int unsigned PULSE_LEN = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  edge_gen_if.slave  bus
);

  if ((MIN_HIGH > (2**CNT_W)) || (MIN_LOW > (2**CNT_W)) || (PULSE_LEN > (2**CNT_W))) begin : g_cnt_w_check
    $error("edge_gen: CNT_W too narrow for configured hold lengths");
  end

`ifdef EDGE_GEN_AUTOFALL_EN
  // Auto-fall keeps a fall pending for the whole high phase; an explicit fall
  // is honoured early once MIN_HIGH cycles have been spent high.
  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] FALL_THR  = CNT_W'(PULSE_LEN - MIN_HIGH);
  localparam logic             AUTO_PEND = 1'b1;
`else
  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] FALL_THR  = '0;
  localparam logic             AUTO_PEND = 1'b0;
`endif
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic             a_q, a_d;
  logic             rdone_q, rdone_d;
  logic             fdone_q, fdone_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero, le_thr;
  logic             rise_v, fall_v;

  edge_hold_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .thr      (FALL_THR),
    .zero     (zero),
    .le_thr   (le_thr)
  );

  assign rise_v = bus.rise_req & ~bus.fall_req;
  assign fall_v = bus.fall_req & ~bus.rise_req;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    a_d      = a_q;
    rdone_d  = 1'b0;
    fdone_d  = 1'b0;
    err_d    = bus.rise_req & bus.fall_req;
    load     = 1'b0;
    load_val = '0;

    // Hold expiry still proceeds on a conflicting-request cycle; only the requests are dropped.
    unique case (state_q)
      LOW_IDLE: begin
        if (rise_v) begin
          state_d = HOLD_HIGH; a_d = 1'b1; rdone_d = 1'b1;
          load = 1'b1; load_val = HIGH_LOAD; pend_d = AUTO_PEND;
        end else if (fall_v) begin
          err_d = 1'b1;
        end
      end
      HOLD_HIGH: begin
        if (rise_v) err_d = 1'b1;
        if ((zero && pend_q) || (fall_v && le_thr)) begin
          state_d = HOLD_LOW; a_d = 1'b0; fdone_d = 1'b1;
          load = 1'b1; load_val = LOW_LOAD; pend_d = 1'b0;
        end else if (zero) begin
          state_d = HIGH_IDLE;
        end else if (fall_v) begin
          pend_d = 1'b1;
        end
      end
      HIGH_IDLE: begin
        if (fall_v) begin
          state_d = HOLD_LOW; a_d = 1'b0; fdone_d = 1'b1;
          load = 1'b1; load_val = LOW_LOAD; pend_d = 1'b0;
        end else if (rise_v) begin
          err_d = 1'b1;
        end
      end
      HOLD_LOW: begin
        if (fall_v) err_d = 1'b1;
        if (zero && (pend_q || rise_v)) begin
          state_d = HOLD_HIGH; a_d = 1'b1; rdone_d = 1'b1;
          load = 1'b1; load_val = HIGH_LOAD; pend_d = AUTO_PEND;
        end else if (zero) begin
          state_d = LOW_IDLE;
        end else if (rise_v) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = LOW_IDLE;
    endcase

    busy_d = (state_d == HOLD_HIGH) || (state_d == HOLD_LOW) || pend_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOW_IDLE;
      pend_q  <= 1'b0;
      a_q     <= 1'b0;
      rdone_q <= 1'b0;
      fdone_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      a_q     <= a_d;
      rdone_q <= rdone_d;
      fdone_q <= fdone_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.a_out     = a_q;
  assign bus.rise_done = rdone_q;
  assign bus.fall_done = fdone_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule
